// File: rtl/inst_encoder.sv
// inst_encoder: turns LEGv8 instruction requests into 32-bit words and
// writes them, one per handshake, into instruction memory.
// Optional immediate range checking is enabled by defining INST_ENC_RANGECHK_EN;
// without it, immediates are truncated to their field width.
module inst_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rn,
    input  logic [4:0]    req_rm,
    input  logic [25:0]   req_imm,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_wr_ack,
    output logic          err,
    output logic          done,
    output logic          full
);

    localparam logic [3:0] OP_LDUR = 4'd0;
    localparam logic [3:0] OP_STUR = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_ORR  = 4'd6;
    localparam logic [3:0] OP_CBZ  = 4'd7;
    localparam logic [3:0] OP_CBNZ = 4'd8;
    localparam logic [3:0] OP_B    = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t          r_state;
    logic            r_wr_en;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            r_is_halt;
    logic            r_err;
    logic            r_done;
    logic            r_full;

    logic [31:0]     w_word;
    logic            w_op_ok;
    logic            w_req_ok;

    // Encode the current request into its instruction word and flag invalid ops
    always_comb begin
        w_word  = '0;
        w_op_ok = 1'b1;
        unique case (req_op)
            OP_LDUR: w_word = {11'b11111000010, req_imm[8:0], 2'b00, req_rn, req_rd};
            OP_STUR: w_word = {11'b11111000000, req_imm[8:0], 2'b00, req_rn, req_rd};
            OP_ADD:  w_word = {11'b10001011000, req_rm, 6'd0, req_rn, req_rd};
            OP_ADDI: w_word = {10'b1001000100, req_imm[11:0], req_rn, req_rd};
            OP_SUB:  w_word = {11'b11001011000, req_rm, 6'd0, req_rn, req_rd};
            OP_AND:  w_word = {11'b10001010000, req_rm, 6'd0, req_rn, req_rd};
            OP_ORR:  w_word = {11'b10101010000, req_rm, 6'd0, req_rn, req_rd};
            OP_CBZ:  w_word = {8'b10110100, req_imm[18:0], req_rd};
            OP_CBNZ: w_word = {8'b10110101, req_imm[18:0], req_rd};
            OP_B:    w_word = {6'b000101, req_imm[25:0]};
            OP_HALT: w_word = '1;
            default: w_op_ok = 1'b0;
        endcase
    end

`ifdef INST_ENC_RANGECHK_EN
    logic w_imm_ok;

    // Signed fields fit when every bit above the field copies the field's sign bit
    always_comb begin
        w_imm_ok = 1'b1;
        case (req_op)
            OP_ADDI:           w_imm_ok = (req_imm[25:12] == '0);
            OP_LDUR, OP_STUR:  w_imm_ok = (req_imm[25:8] == '0) || (req_imm[25:8] == '1);
            OP_CBZ, OP_CBNZ:   w_imm_ok = (req_imm[25:18] == '0) || (req_imm[25:18] == '1);
            default:           w_imm_ok = 1'b1;
        endcase
    end

    assign w_req_ok = w_op_ok && w_imm_ok;
`else
    assign w_req_ok = w_op_ok;
`endif

    assign req_ready = (r_state == IDLE);
    assign mem_wr_en = r_wr_en;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign err       = r_err;
    assign done      = r_done;
    assign full      = r_full;

    // Control FSM: accept in IDLE, hold the write until acked, park in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_halt <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_req_ok) begin
                            r_wdata   <= w_word;
                            r_is_halt <= (req_op == OP_HALT);
                            r_wr_en   <= 1'b1;
                            r_state   <= WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        r_wr_en <= 1'b0;
                        if (r_is_halt) begin
                            r_done  <= 1'b1;
                            r_full  <= (r_addr == LAST_ADDR);
                            r_state <= DONE;
                        end else if (r_addr == LAST_ADDR) begin
                            r_full  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
